dpram_stream_reader: RTL and testbench

Read-side sequencer for the `DPRAM` port used by the shell. On a `start` command it streams `length` consecutive words, beginning at `base_addr`, out of one RAM port onto a valid/ready stream. It hides the RAM's 1-cycle read latency behind a 2-entry output buffer, so it sustains 1 word/cycle while `m_ready` is held high. It drives only the enable and address of a read-only port; `we` is tied low and `rst` is tied inactive by the instantiating level.

---
 rtl/dpram_stream_reader.sv | 148 ++++++++++++++
 tb/tb_dpram_stream_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_stream_reader.sv
// Streams a run of consecutive words out of one read-only RAM port onto a
// valid/ready interface, covering the RAM's 1-cycle read latency with a 2-entry buffer.
module dpram_stream_reader #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_en,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_last
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]               state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] ptr_reg, ptr_next;
  logic [ADDRESS_WIDTH:0]   remain_reg, remain_next;
  logic                     inflight_reg;
  logic                     inflight_last_reg;
  logic                     done_reg;

  logic [1:0]               count_reg;
  logic                     wr_sel_reg;
  logic                     rd_sel_reg;
  logic [DATA_WIDTH-1:0]    buf_data [2];
  logic                     buf_last [2];

  logic                     push;
  logic                     pop;
  logic                     issue;
  logic                     last_issue;
  logic                     drained;
  logic [2:0]               occupancy;

  assign push      = inflight_reg;
  assign pop       = m_valid && m_ready;
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg};
  // A read may go out only if its word is guaranteed a buffer slot when it lands.
  assign issue      = (state_reg == ST_RUN) && (occupancy < (3'd2 + {2'b00, pop}));
  assign last_issue = issue && (remain_reg == (ADDRESS_WIDTH+1)'(1));
  assign drained    = (count_reg == 2'd0) && !inflight_reg;

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    remain_next = remain_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          ptr_next    = base_addr;
          remain_next = length;
          state_next  = (length == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          ptr_next    = ptr_reg + ADDRESS_WIDTH'(1);
          remain_next = remain_reg - (ADDRESS_WIDTH+1)'(1);
          if (last_issue) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg         <= ST_IDLE;
      ptr_reg           <= '0;
      remain_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      ptr_reg           <= ptr_next;
      remain_reg        <= remain_next;
      inflight_reg      <= issue;
      inflight_last_reg <= last_issue;
      done_reg          <= (state_reg == ST_DRAIN) && drained;
    end
  end

  // Occupancy and ring pointers of the output buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg  <= 2'd0;
      wr_sel_reg <= 1'b0;
      rd_sel_reg <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
      if (push) begin
        wr_sel_reg <= !wr_sel_reg;
      end
      if (pop) begin
        rd_sel_reg <= !rd_sel_reg;
      end
    end
  end

  // Returning read data is always captured, so the RAM output register never holds state.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    localparam logic ENTRY = (gi == 1);
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        buf_data[gi] <= '0;
        buf_last[gi] <= 1'b0;
      end else if (push && (wr_sel_reg == ENTRY)) begin
        buf_data[gi] <= ram_dout;
        buf_last[gi] <= inflight_last_reg;
      end
    end
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign ram_en   = issue;
  assign ram_addr = ptr_reg;
  assign m_valid  = (count_reg != 2'd0);
  assign m_data   = buf_data[rd_sel_reg];
  assign m_last   = buf_last[rd_sel_reg];

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench for dpram_stream_reader: a behavioural RAM, a beat monitor,
// and a linear sequence of transfers checked against hand-derived expectations.
module tb_dpram_stream_reader;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [9:0]   base_addr;
  logic [10:0]  length;
  logic         busy;
  logic         done;
  logic         ram_en;
  logic [9:0]   ram_addr;
  logic [127:0] ram_dout;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         m_last;

  int total = 0;
  int bad   = 0;

  logic [127:0] mem [1024];
  logic [128:0] beats [$];
  int           cyc = 0;
  int           base_cyc = 0;
  int           first_valid = -1;
  int           en_cnt = 0;
  int           done_cnt = 0;
  bit           rand_ready = 0;
  bit           hold = 0;
  logic [127:0] hold_data;
  logic         hold_last;

  dpram_stream_reader #(.DATA_WIDTH(128), .ADDRESS_WIDTH(10)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] word(input int a);
    int w = a & 1023;
    return {32'(w) ^ 32'hA5A50000, 32'(w) * 32'd3 + 32'd7, ~32'(w), 32'(w)};
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = word(i);
  end

  always @(posedge clk) begin
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: records accepted beats and checks that a stalled beat holds still.
  always @(negedge clk) begin
    cyc++;
    if (ram_en) en_cnt++;
    if (done) done_cnt++;
    if (!rstn) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", 128'(m_valid), 128'(1));
        chk("hold_data", m_data, hold_data);
        chk("hold_last", 128'(m_last), 128'(hold_last));
      end
      if (m_valid && m_ready) beats.push_back({m_last, m_data});
      hold      = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
      if (m_valid && first_valid < 0) first_valid = cyc - base_cyc;
    end
  end

  // Called off-edge; start is sampled at the next rising edge.
  task automatic start_xfer(input int b, input int n);
    beats.delete();
    en_cnt      = 0;
    done_cnt    = 0;
    first_valid = -1;
    start       = 1'b1;
    base_addr   = 10'(b);
    length      = 11'(n);
    @(posedge clk);
    #1;
    start    = 1'b0;
    base_cyc = cyc + 1;
    chk("busy_rise", 128'(busy), 128'(1));
    chk("first_en", 128'(ram_en), 128'(n != 0));
    if (n != 0) chk("first_addr", 128'(ram_addr), 128'(b & 1023));
  endtask

  task automatic finish_xfer(input int b, input int n, input bit timed);
    bit got = 0;
    int errs = 0;
    for (int k = 0; k < n * 8 + 50; k++) begin
      @(negedge clk);
      #1;
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", 128'(got), 128'(1));
    chk("busy_at_done", 128'(busy), 128'(0));
    if (timed) begin
      chki("done_cycle", cyc - base_cyc, (n == 0) ? 1 : n + 3);
      chki("first_valid_cycle", first_valid, (n == 0) ? -1 : 2);
    end
    for (int i = 0; i < beats.size(); i++) begin
      if (beats[i][127:0] !== word(b + i) || beats[i][128] !== (i == n - 1)) errs++;
    end
    chki("beat_count", beats.size(), n);
    chki("beat_errs", errs, 0);
    if (n > 0 && beats.size() > 0) begin
      chk("first_beat", beats[0][127:0], word(b));
      chk("last_beat", beats[$][127:0], word(b + n - 1));
      chk("last_flag", 128'(beats[$][128]), 128'(1));
    end
    chki("ram_en_count", en_cnt, n);
    chki("done_count", done_cnt, 1);
  endtask

  task automatic chk_zero_outputs();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_ram_en", 128'(ram_en), 128'(0));
    chk("rst_ram_addr", 128'(ram_addr), 128'(0));
    chk("rst_m_valid", 128'(m_valid), 128'(0));
    chk("rst_m_data", m_data, 128'(0));
    chk("rst_m_last", 128'(m_last), 128'(0));
  endtask

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b1;
    #1;
    chk_zero_outputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;

    // Full-throughput burst, then wrap-around started in the done cycle.
    start_xfer(5, 4);
    finish_xfer(5, 4, 1);
    start_xfer(1022, 4);
    finish_xfer(1022, 4, 1);

    // Zero length.
    start_xfer(7, 0);
    finish_xfer(7, 0, 1);

    // Full depth.
    start_xfer(200, 1024);
    finish_xfer(200, 1024, 1);

    // Deterministic stall: buffer fills, issue stops, resumes with m_ready.
    m_ready = 1'b0;
    start_xfer(300, 6);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_valid", 128'(m_valid), 128'(1));
    chk("stall_en", 128'(ram_en), 128'(0));
    chk("stall_data", m_data, word(300));
    chki("stall_en_count", en_cnt, 2);
    @(posedge clk);
    #1;
    chk("stall_data2", m_data, word(300));
    m_ready = 1'b1;
    #1;
    chk("resume_en", 128'(ram_en), 128'(1));
    chk("resume_addr", 128'(ram_addr), 128'(302));
    finish_xfer(300, 6, 0);

    // Random backpressure, including a wrapping run.
    rand_ready = 1;
    start_xfer(40, 8);
    finish_xfer(40, 8, 0);
    start_xfer(1020, 16);
    finish_xfer(1020, 16, 0);
    rand_ready = 0;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    #1;

    // Start pulsed while busy must be ignored.
    start_xfer(100, 8);
    repeat (3) @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 10'd500;
    length    = 11'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_xfer(100, 8, 1);

    // Reset mid-burst, then a clean transfer.
    start_xfer(50, 20);
    repeat (5) @(posedge clk);
    #1;
    done_cnt = 0;
    rstn = 1'b0;
    #1;
    chk_zero_outputs();
    repeat (3) @(negedge clk);
    #1;
    chki("rst_no_done", done_cnt, 0);
    chk("rst_hold_valid", 128'(m_valid), 128'(0));
    rstn = 1'b1;
    start_xfer(60, 5);
    finish_xfer(60, 5, 1);

    repeat (3) @(negedge clk);
    #1;
    chk("final_idle", 128'(busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
